// File: rtl/data_path_pkg.sv
// Shared constants for the mini-CPU datapath: ALU op codes, branch condition codes,
// IR field layout and the C-immediate sign extension helper.
package data_path_pkg;

   localparam int DATA_W = 32;

   localparam int OPCODE_HI = 31;
   localparam int OPCODE_LO = 27;
   localparam int RA_HI     = 26;
   localparam int RA_LO     = 23;
   localparam int RB_HI     = 22;
   localparam int RB_LO     = 19;
   localparam int RC_HI     = 18;
   localparam int RC_LO     = 15;
   localparam int C_HI      = 18;
   localparam int C2_HI     = 20;
   localparam int C2_LO     = 19;

   typedef enum logic [4:0] {
      OP_PASS = 5'b00000,
      OP_ADD  = 5'b00011,
      OP_SUB  = 5'b00100,
      OP_AND  = 5'b00101,
      OP_OR   = 5'b00110,
      OP_ROR  = 5'b00111,
      OP_ROL  = 5'b01000,
      OP_SHR  = 5'b01001,
      OP_SHRA = 5'b01010,
      OP_SHL  = 5'b01011,
      OP_MUL  = 5'b01111,
      OP_DIV  = 5'b10000,
      OP_NEG  = 5'b10001,
      OP_NOT  = 5'b10010
   } alu_op_t;

   typedef enum logic [1:0] {
      COND_ZERO    = 2'b00,
      COND_NONZERO = 2'b01,
      COND_POS     = 2'b10,
      COND_NEG     = 2'b11
   } cond_t;

   function automatic logic [DATA_W-1:0] sign_ext_c(input logic [C_HI:0] c);
      return {{(DATA_W-C_HI-1){c[C_HI]}}, c};
   endfunction

endpackage

// File: rtl/data_path_alu.sv
// Datapath ALU: A is the Y register, B is the bus; produces a 64-bit result whose
// high word is only non-zero for mul (product high) and div (remainder).
module data_path_alu
   import data_path_pkg::*;
(
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   input  logic [4:0]          op,
   input  logic                inc_pc,
   output logic [2*DATA_W-1:0] result
);

   logic [4:0]                 shamt;
   logic [2*DATA_W-1:0]        dbl;
   logic [2*DATA_W-1:0]        ror_w;
   logic [2*DATA_W-1:0]        rol_w;
   logic [DATA_W-1:0]          sra_w;
   logic signed [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]          quo;
   logic [DATA_W-1:0]          rem;

   // Rotates shift a doubled copy of A so the wrapped bits fall out naturally.
   assign shamt = b[4:0];
   assign dbl   = {a, a};
   assign ror_w = dbl >> shamt;
   assign rol_w = dbl << shamt;
   assign sra_w = $signed(a) >>> shamt;
   assign prod  = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});

   always_comb begin
      quo = '0;
      rem = '0;
      if (b != '0) begin
         quo = $signed(a) / $signed(b);
         rem = $signed(a) % $signed(b);
      end
   end

   always_comb begin
      result = '0;
      if (inc_pc) begin
         result = {{DATA_W{1'b0}}, b + DATA_W'(1)};
      end else begin
         case (op)
            OP_PASS: result = {{DATA_W{1'b0}}, b};
            OP_ADD:  result = {{DATA_W{1'b0}}, a + b};
            OP_SUB:  result = {{DATA_W{1'b0}}, a - b};
            OP_AND:  result = {{DATA_W{1'b0}}, a & b};
            OP_OR:   result = {{DATA_W{1'b0}}, a | b};
            OP_ROR:  result = {{DATA_W{1'b0}}, ror_w[DATA_W-1:0]};
            OP_ROL:  result = {{DATA_W{1'b0}}, rol_w[2*DATA_W-1:DATA_W]};
            OP_SHR:  result = {{DATA_W{1'b0}}, a >> shamt};
            OP_SHRA: result = {{DATA_W{1'b0}}, sra_w};
            OP_SHL:  result = {{DATA_W{1'b0}}, a << shamt};
            OP_MUL:  result = prod;
            OP_DIV:  result = {rem, quo};
            OP_NEG:  result = {{DATA_W{1'b0}}, -b};
            OP_NOT:  result = {{DATA_W{1'b0}}, ~b};
            default: result = '0;
         endcase
      end
   end

endmodule

// File: rtl/data_path.sv
// Single-bus 32-bit mini-CPU datapath driven strobe-by-strobe by an external controller.
// RAM starts zeroed at power-up and is not affected by clear.
module data_path
   import data_path_pkg::*;
#(
   parameter int    RAM_DEPTH     = 512,
   parameter string RAM_INIT_FILE = "ram_init.hex"
) (
   input  logic              Clock,
   input  logic              clear,
   input  logic              Read,
   input  logic              Write,
   input  logic              strobe,
   input  logic              BAOut,
   input  logic              Gra,
   input  logic              Grb,
   input  logic              Grc,
   input  logic              Rin,
   input  logic              Rout,
   input  logic [DATA_W-1:0] input_data,
   input  logic              IRin,
   input  logic [4:0]        op,
   input  logic              HIOut,
   input  logic              LOout,
   input  logic              Zhighout,
   input  logic              Zlowout,
   input  logic              PCout,
   input  logic              MDRout,
   input  logic              InPortout,
   input  logic              Yout,
   input  logic              RAMout,
   input  logic              Cout,
   input  logic              HIin,
   input  logic              LOin,
   input  logic              ZHighin,
   input  logic              Zlowin,
   input  logic              PCin,
   input  logic              MDRin,
   input  logic              OutPortin,
   input  logic              Yin,
   input  logic              MARin,
   input  logic              IncPC,
   output logic [DATA_W-1:0] BusOut,
   output logic [DATA_W-1:0] mdrData,
   output logic [DATA_W-1:0] ZHighWire,
   output logic [DATA_W-1:0] ZLowWire,
   output logic [DATA_W-1:0] BusMuxInR0,
   output logic [DATA_W-1:0] BusMuxInR1,
   output logic [DATA_W-1:0] BusMuxInR2,
   output logic [DATA_W-1:0] BusMuxInR3,
   output logic [DATA_W-1:0] BusMuxInR4,
   output logic [DATA_W-1:0] BusMuxInR5,
   output logic [DATA_W-1:0] BusMuxInR6,
   output logic [DATA_W-1:0] BusMuxInR7,
   output logic [DATA_W-1:0] BusMuxInR8,
   output logic [DATA_W-1:0] BusMuxInR9,
   output logic [DATA_W-1:0] BusMuxInR10,
   output logic [DATA_W-1:0] BusMuxInR11,
   output logic [DATA_W-1:0] BusMuxInR12,
   output logic [DATA_W-1:0] BusMuxInR13,
   output logic [DATA_W-1:0] BusMuxInR14,
   output logic [DATA_W-1:0] BusMuxInR15,
   output logic [DATA_W-1:0] BusMuxInZhigh,
   output logic [DATA_W-1:0] BusMuxInZlow,
   output logic [DATA_W-1:0] BusMuxInPCout,
   output logic [DATA_W-1:0] BusMuxInInPortout,
   output logic [DATA_W-1:0] BusMuxInYout,
   output logic [DATA_W-1:0] BusMuxInHI,
   output logic [DATA_W-1:0] BusMuxInLO,
   output logic [DATA_W-1:0] BusMuxInRamout,
   output logic [DATA_W-1:0] output_data,
   output logic [DATA_W-1:0] irOut,
   output logic              branchCompare,
   output logic R0out,  output logic R1out,  output logic R2out,  output logic R3out,
   output logic R4out,  output logic R5out,  output logic R6out,  output logic R7out,
   output logic R8out,  output logic R9out,  output logic R10out, output logic R11out,
   output logic R12out, output logic R13out, output logic R14out, output logic R15out,
   output logic R0in,   output logic R1in,   output logic R2in,   output logic R3in,
   output logic R4in,   output logic R5in,   output logic R6in,   output logic R7in,
   output logic R8in,   output logic R9in,   output logic R10in,  output logic R11in,
   output logic R12in,  output logic R13in,  output logic R14in,  output logic R15in,
   output logic [3:0]        to_decode
);

   localparam int ADDR_W = $clog2(RAM_DEPTH);

   logic [DATA_W-1:0]   gpr [16];
   logic [DATA_W-1:0]   pc, ir, mdr, y, hi, lo, in_port, out_port;
   logic [2*DATA_W-1:0] z;
   logic [ADDR_W-1:0]   mar;
   logic [DATA_W-1:0]   ram [RAM_DEPTH];
   logic [DATA_W-1:0]   ram_rd, c_ext, bus;
   logic [2*DATA_W-1:0] alu_res;
   logic [3:0]          reg_idx;
   logic [15:0]         sel, reg_in, reg_out;
   logic                branch;

   // Register select: OR of the enabled IR register fields, then one-hot decode.
   assign reg_idx = (Gra ? ir[RA_HI:RA_LO] : 4'd0) |
                    (Grb ? ir[RB_HI:RB_LO] : 4'd0) |
                    (Grc ? ir[RC_HI:RC_LO] : 4'd0);
   assign sel     = 16'd1 << reg_idx;
   assign reg_in  = {16{Rin}} & sel;
   assign reg_out = {16{Rout | BAOut}} & sel;
   assign c_ext   = sign_ext_c(ir[C_HI:0]);
   assign ram_rd  = ram[mar];

   // Later assignments win, so the list runs from lowest to highest priority.
   always_comb begin
      bus = '0;
      if (RAMout)    bus = ram_rd;
      if (Yout)      bus = y;
      if (Cout)      bus = c_ext;
      if (InPortout) bus = in_port;
      if (MDRout)    bus = mdr;
      if (PCout)     bus = pc;
      if (Zlowout)   bus = z[DATA_W-1:0];
      if (Zhighout)  bus = z[2*DATA_W-1:DATA_W];
      if (LOout)     bus = lo;
      if (HIOut)     bus = hi;
      for (int i = 15; i >= 1; i--) begin
         if (reg_out[i]) bus = gpr[i];
      end
      if (reg_out[0]) bus = BAOut ? '0 : gpr[0];
   end

   data_path_alu u_alu (
      .a      (y),
      .b      (bus),
      .op     (op),
      .inc_pc (IncPC),
      .result (alu_res)
   );

   always_comb begin
      branch = 1'b0;
      case (ir[C2_HI:C2_LO])
         COND_ZERO:    branch = (bus == '0);
         COND_NONZERO: branch = (bus != '0);
         COND_POS:     branch = !bus[DATA_W-1] && (bus != '0);
         COND_NEG:     branch = bus[DATA_W-1];
         default:      branch = 1'b0;
      endcase
   end

   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         for (int i = 0; i < 16; i++) gpr[i] <= '0;
         pc       <= '0;
         ir       <= '0;
         mar      <= '0;
         mdr      <= '0;
         y        <= '0;
         z        <= '0;
         hi       <= '0;
         lo       <= '0;
         in_port  <= '0;
         out_port <= '0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (reg_in[i]) gpr[i] <= bus;
         end
         if (PCin)      pc       <= bus;
         if (IRin)      ir       <= bus;
         if (MARin)     mar      <= bus[ADDR_W-1:0];
         if (MDRin)     mdr      <= Read ? ram_rd : bus;
         if (Yin)       y        <= bus;
         if (HIin)      hi       <= bus;
         if (LOin)      lo       <= bus;
         if (ZHighin)   z[2*DATA_W-1:DATA_W] <= alu_res[2*DATA_W-1:DATA_W];
         if (Zlowin)    z[DATA_W-1:0]        <= alu_res[DATA_W-1:0];
         if (strobe)    in_port  <= input_data;
         if (OutPortin) out_port <= bus;
      end
   end

   // RAM is deliberately outside the clear domain; a same-edge read sees the old word.
   always_ff @(posedge Clock) begin
      if (Write) ram[mar] <= mdr;
   end

   initial begin
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] = '0;
   end

   assign BusOut            = bus;
   assign mdrData           = mdr;
   assign ZHighWire         = alu_res[2*DATA_W-1:DATA_W];
   assign ZLowWire          = alu_res[DATA_W-1:0];
   assign BusMuxInZhigh     = z[2*DATA_W-1:DATA_W];
   assign BusMuxInZlow      = z[DATA_W-1:0];
   assign BusMuxInPCout     = pc;
   assign BusMuxInInPortout = in_port;
   assign BusMuxInYout      = y;
   assign BusMuxInHI        = hi;
   assign BusMuxInLO        = lo;
   assign BusMuxInRamout    = ram_rd;
   assign output_data       = out_port;
   assign irOut             = ir;
   assign branchCompare     = branch;
   assign to_decode         = reg_idx;

   assign BusMuxInR0  = gpr[0];   assign BusMuxInR1  = gpr[1];
   assign BusMuxInR2  = gpr[2];   assign BusMuxInR3  = gpr[3];
   assign BusMuxInR4  = gpr[4];   assign BusMuxInR5  = gpr[5];
   assign BusMuxInR6  = gpr[6];   assign BusMuxInR7  = gpr[7];
   assign BusMuxInR8  = gpr[8];   assign BusMuxInR9  = gpr[9];
   assign BusMuxInR10 = gpr[10];  assign BusMuxInR11 = gpr[11];
   assign BusMuxInR12 = gpr[12];  assign BusMuxInR13 = gpr[13];
   assign BusMuxInR14 = gpr[14];  assign BusMuxInR15 = gpr[15];

   assign {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
           R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out} = reg_out;
   assign {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
           R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in} = reg_in;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: instruction fetch/load, BAOut, store, branch,
// ALU vectors and an asynchronous clear in the middle of an instruction.
module tb_data_path;
   import data_path_pkg::*;

   logic        Clock = 1'b0;
   logic        clear = 1'b0;
   logic        Read, Write, strobe, BAOut, Gra, Grb, Grc, Rin, Rout, IRin;
   logic [31:0] input_data;
   logic [4:0]  op;
   logic        HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, RAMout, Cout;
   logic        HIin, LOin, ZHighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC;

   wire [31:0] bus_out, mdr_data, zhigh_wire, zlow_wire;
   wire [31:0] gpr_val [16];
   wire [31:0] zhigh, zlow, pc_val, inport_val, y_val, hi_val, lo_val, ram_val;
   wire [31:0] out_data, ir_val;
   wire        branch;
   wire [15:0] rx_out, rx_in;
   wire [3:0]  to_decode;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   data_path dut (
      .Clock(Clock), .clear(clear), .Read(Read), .Write(Write), .strobe(strobe),
      .BAOut(BAOut), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
      .input_data(input_data), .IRin(IRin), .op(op),
      .HIOut(HIOut), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout), .PCout(PCout),
      .MDRout(MDRout), .InPortout(InPortout), .Yout(Yout), .RAMout(RAMout), .Cout(Cout),
      .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin), .Zlowin(Zlowin), .PCin(PCin),
      .MDRin(MDRin), .OutPortin(OutPortin), .Yin(Yin), .MARin(MARin), .IncPC(IncPC),
      .BusOut(bus_out), .mdrData(mdr_data), .ZHighWire(zhigh_wire), .ZLowWire(zlow_wire),
      .BusMuxInR0(gpr_val[0]),   .BusMuxInR1(gpr_val[1]),   .BusMuxInR2(gpr_val[2]),
      .BusMuxInR3(gpr_val[3]),   .BusMuxInR4(gpr_val[4]),   .BusMuxInR5(gpr_val[5]),
      .BusMuxInR6(gpr_val[6]),   .BusMuxInR7(gpr_val[7]),   .BusMuxInR8(gpr_val[8]),
      .BusMuxInR9(gpr_val[9]),   .BusMuxInR10(gpr_val[10]), .BusMuxInR11(gpr_val[11]),
      .BusMuxInR12(gpr_val[12]), .BusMuxInR13(gpr_val[13]), .BusMuxInR14(gpr_val[14]),
      .BusMuxInR15(gpr_val[15]),
      .BusMuxInZhigh(zhigh), .BusMuxInZlow(zlow), .BusMuxInPCout(pc_val),
      .BusMuxInInPortout(inport_val), .BusMuxInYout(y_val), .BusMuxInHI(hi_val),
      .BusMuxInLO(lo_val), .BusMuxInRamout(ram_val),
      .output_data(out_data), .irOut(ir_val), .branchCompare(branch),
      .R0out(rx_out[0]),   .R1out(rx_out[1]),   .R2out(rx_out[2]),   .R3out(rx_out[3]),
      .R4out(rx_out[4]),   .R5out(rx_out[5]),   .R6out(rx_out[6]),   .R7out(rx_out[7]),
      .R8out(rx_out[8]),   .R9out(rx_out[9]),   .R10out(rx_out[10]), .R11out(rx_out[11]),
      .R12out(rx_out[12]), .R13out(rx_out[13]), .R14out(rx_out[14]), .R15out(rx_out[15]),
      .R0in(rx_in[0]),     .R1in(rx_in[1]),     .R2in(rx_in[2]),     .R3in(rx_in[3]),
      .R4in(rx_in[4]),     .R5in(rx_in[5]),     .R6in(rx_in[6]),     .R7in(rx_in[7]),
      .R8in(rx_in[8]),     .R9in(rx_in[9]),     .R10in(rx_in[10]),   .R11in(rx_in[11]),
      .R12in(rx_in[12]),   .R13in(rx_in[13]),   .R14in(rx_in[14]),   .R15in(rx_in[15]),
      .to_decode(to_decode)
   );

   // Clock / reset
   always #5 Clock = ~Clock;

   task automatic pulse_clear();
      clear = 1'b1;
      #2;
      clear = 1'b0;
   endtask

   // Driver tasks
   task automatic idle();
      {Read, Write, strobe, BAOut, Gra, Grb, Grc, Rin, Rout, IRin} = '0;
      {HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, RAMout, Cout} = '0;
      {HIin, LOin, ZHighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC} = '0;
      op = OP_PASS;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   // Latches v into the in-port and leaves it driving the bus for the caller's next cycle.
   task automatic drive_in(input logic [31:0] v);
      idle();
      input_data = v;
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      InPortout = 1'b1;
   endtask

   task automatic ram_write(input logic [31:0] addr, input logic [31:0] data);
      drive_in(addr); MARin = 1'b1; tick();
      drive_in(data); MDRin = 1'b1; tick();
      idle(); Write = 1'b1; tick();
      idle();
   endtask

   task automatic fetch_t0_t3();
      idle(); PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; tick();
      idle(); Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; tick();
      idle(); MDRout = 1'b1; IRin = 1'b1; tick();
      idle(); Grb = 1'b1; BAOut = 1'b1; Yin = 1'b1; tick();
   endtask

   // Scoreboard
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [31:0] y;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } alu_vec_t;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] v;
      logic        exp;
   } br_vec_t;

   alu_vec_t alu_vecs [19];
   br_vec_t  br_vecs [8];

   initial begin
      alu_vecs[0]  = '{OP_SUB,  32'd7,          32'd3,          32'h0,        32'h4};
      alu_vecs[1]  = '{OP_MUL,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'hFFFF_FFF2};
      alu_vecs[2]  = '{OP_DIV,  32'd7,          32'd3,          32'h1,        32'h2};
      alu_vecs[3]  = '{OP_ADD,  32'd7,          32'd3,          32'h0,        32'hA};
      alu_vecs[4]  = '{OP_AND,  32'd7,          32'd3,          32'h0,        32'h3};
      alu_vecs[5]  = '{OP_OR,   32'd7,          32'd3,          32'h0,        32'h7};
      alu_vecs[6]  = '{OP_ROR,  32'h8000_0001,  32'd1,          32'h0,        32'hC000_0000};
      alu_vecs[7]  = '{OP_ROL,  32'h8000_0001,  32'd1,          32'h0,        32'h0000_0003};
      alu_vecs[8]  = '{OP_SHR,  32'h8000_0001,  32'd1,          32'h0,        32'h4000_0000};
      alu_vecs[9]  = '{OP_SHRA, 32'h8000_0001,  32'd1,          32'h0,        32'hC000_0000};
      alu_vecs[10] = '{OP_SHL,  32'h8000_0001,  32'd1,          32'h0,        32'h0000_0002};
      alu_vecs[11] = '{OP_NEG,  32'd0,          32'd3,          32'h0,        32'hFFFF_FFFD};
      alu_vecs[12] = '{OP_NOT,  32'd0,          32'd3,          32'h0,        32'hFFFF_FFFC};
      alu_vecs[13] = '{OP_PASS, 32'd0,          32'h1234,       32'h0,        32'h1234};
      alu_vecs[14] = '{5'b00001, 32'd7,         32'd3,          32'h0,        32'h0};
      alu_vecs[15] = '{OP_DIV,  32'd7,          32'd0,          32'h0,        32'h0};
      alu_vecs[16] = '{OP_ROR,  32'h1234_5678,  32'd4,          32'h0,        32'h8123_4567};
      alu_vecs[17] = '{OP_MUL,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  32'h0,        32'h6};
      alu_vecs[18] = '{OP_SHR,  32'h8000_0001,  32'd33,         32'h0,        32'h4000_0000};

      br_vecs[0] = '{32'h0010_0000, 32'd50,         1'b1};
      br_vecs[1] = '{32'h0010_0000, 32'd0,          1'b0};
      br_vecs[2] = '{32'h0010_0000, 32'hFFFF_FFFF,  1'b0};
      br_vecs[3] = '{32'h0018_0000, 32'hFFFF_FFFF,  1'b1};
      br_vecs[4] = '{32'h0018_0000, 32'd50,         1'b0};
      br_vecs[5] = '{32'h0000_0000, 32'd0,          1'b1};
      br_vecs[6] = '{32'h0008_0000, 32'd0,          1'b0};
      br_vecs[7] = '{32'h0008_0000, 32'd9,          1'b1};

      idle();
      input_data = '0;
      #1;
      pulse_clear();
      check("reset_bus", bus_out, 32'h0);
      check("reset_pc", pc_val, 32'h0);
      check("reset_mdr", mdr_data, 32'h0);
      check("reset_zlow", zlow, 32'h0);

      // ld R1,0x65(R0)
      ram_write(32'h0, 32'h0080_0065);
      ram_write(32'h65, 32'h0000_0084);
      pulse_clear();
      idle(); PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
      #1 check("t0_incpc", zlow_wire, 32'h1);
      tick();
      idle(); Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; tick();
      check("t1_pc", pc_val, 32'h1);
      idle(); MDRout = 1'b1; IRin = 1'b1; tick();
      check("t2_ir", ir_val, 32'h0080_0065);
      idle(); Grb = 1'b1; BAOut = 1'b1; Yin = 1'b1; tick();
      idle(); Cout = 1'b1; Zlowin = 1'b1; op = OP_ADD;
      #1 check("t4_cbus", bus_out, 32'h65);
      tick();
      check("t4_zlow", zlow, 32'h65);
      idle(); Zlowout = 1'b1; MARin = 1'b1; tick();
      idle(); Read = 1'b1; MDRin = 1'b1; tick();
      check("t6_mdr", mdr_data, 32'h84);
      idle(); Gra = 1'b1; Rin = 1'b1; MDRout = 1'b1;
      #1 check("t7_decode", {28'h0, to_decode}, 32'h1);
      check("t7_rin", {16'h0, rx_in}, 32'h2);
      tick();
      check("t7_r1", gpr_val[1], 32'h84);
      check("t7_pc", pc_val, 32'h1);
      check("t7_ir", ir_val, 32'h0080_0065);

      // BAOut on R0 versus Rout on R0 (IR Rb = 0)
      drive_in(32'h55); Rin = 1'b1; tick();
      check("r0_load", gpr_val[0], 32'h55);
      drive_in(32'h99); Yin = 1'b1; tick();
      check("y_preload", y_val, 32'h99);
      idle(); Grb = 1'b1; BAOut = 1'b1; Yin = 1'b1;
      #1 check("baout_bus", bus_out, 32'h0);
      check("baout_rout", {16'h0, rx_out}, 32'h1);
      tick();
      check("baout_y", y_val, 32'h0);
      idle(); Grb = 1'b1; Rout = 1'b1;
      #1 check("rout_bus", bus_out, 32'h55);
      drive_in(32'h77); Rout = 1'b1;
      #1 check("bus_priority", bus_out, 32'h55);

      // Store
      ram_write(32'h10, 32'hDEAD_BEEF);
      idle(); RAMout = 1'b1;
      #1 check("store_ram", ram_val, 32'hDEAD_BEEF);
      check("store_bus", bus_out, 32'hDEAD_BEEF);
      drive_in(32'h1234_5678); MDRin = 1'b1; tick();
      idle(); Read = 1'b1; MDRin = 1'b1; Write = 1'b1; tick();
      check("rw_old_data", mdr_data, 32'hDEAD_BEEF);
      idle(); RAMout = 1'b1;
      #1 check("rw_ram", ram_val, 32'h1234_5678);

      // Branch conditions
      for (int i = 0; i < 8; i++) begin
         drive_in(br_vecs[i].ir); IRin = 1'b1; tick();
         drive_in(br_vecs[i].v); MDRin = 1'b1; tick();
         idle(); MDRout = 1'b1;
         #1 check($sformatf("branch%0d", i), {31'h0, branch}, {31'h0, br_vecs[i].exp});
      end

      // ALU vectors, latched through Z
      for (int i = 0; i < 19; i++) begin
         drive_in(alu_vecs[i].y); Yin = 1'b1; tick();
         drive_in(alu_vecs[i].b); op = alu_vecs[i].op; ZHighin = 1'b1; Zlowin = 1'b1;
         exp_q.push_back(alu_vecs[i].hi);
         exp_q.push_back(alu_vecs[i].lo);
         tick();
         check($sformatf("alu%0d_hi", i), zhigh, exp_q.pop_front());
         check($sformatf("alu%0d_lo", i), zlow, exp_q.pop_front());
      end
      drive_in(32'd9); op = OP_SUB; IncPC = 1'b1;
      #1 check("incpc_override_lo", zlow_wire, 32'd10);
      check("incpc_override_hi", zhigh_wire, 32'd0);

      // Asynchronous clear during T4
      drive_in(32'h11); HIin = 1'b1; tick();
      drive_in(32'h22); LOin = 1'b1; OutPortin = 1'b1; tick();
      check("hi_load", hi_val, 32'h11);
      check("outport_load", out_data, 32'h22);
      ram_write(32'h1, 32'h0080_0065);
      fetch_t0_t3();
      idle(); Cout = 1'b1; Zlowin = 1'b1; op = OP_ADD;
      #1 clear = 1'b1;
      #1;
      for (int i = 0; i < 16; i++) check($sformatf("clr_r%0d", i), gpr_val[i], 32'h0);
      check("clr_zhigh", zhigh, 32'h0);
      check("clr_zlow", zlow, 32'h0);
      check("clr_pc", pc_val, 32'h0);
      check("clr_inport", inport_val, 32'h0);
      check("clr_y", y_val, 32'h0);
      check("clr_hi", hi_val, 32'h0);
      check("clr_lo", lo_val, 32'h0);
      check("clr_mdr", mdr_data, 32'h0);
      check("clr_ir", ir_val, 32'h0);
      check("clr_outport", out_data, 32'h0);
      check("clr_ram_kept", ram_val, 32'h0080_0065);
      clear = 1'b0;
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- 32-bit single-bus CPU datapath for the mini CPU: 16 GPRs (R0–R15), PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, in/out ports, ALU, 512x32 RAM, select-and-encode logic and branch-condition evaluation.
- An external control unit or testbench drives all control strobes cycle by cycle.
- All register contents are exported for debug.

Parameters:
- RAM_DEPTH, 512, memory words; address is MAR[8:0].
- RAM_INIT_FILE, "ram_init.hex", hex image used when the optional feature is enabled.

Ports:
- Clock in 1: rising-edge clock.
- clear in 1: asynchronous, active-high reset.
- Read, Write, strobe, BAOut, Gra, Grb, Grc, Rin, Rout in 1 each: memory, in-port and register-select controls.
- input_data in 32: external in-port data.
- IRin in 1: IR load.
- op in 5: ALU operation.
- HIOut, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Yout, RAMout, Cout in 1 each: bus-drive selects.
- HIin, LOin, ZHighin, Zlowin, PCin, MDRin, OutPortin, Yin, MARin, IncPC in 1 each: register loads and PC-increment ALU override.
- BusOut out 32: current bus value.
- mdrData out 32: MDR contents.
- ZHighWire, ZLowWire out 32 each: combinational ALU result, high and low halves.
- BusMuxInR0..BusMuxInR15, BusMuxInZhigh, BusMuxInZlow, BusMuxInPCout, BusMuxInInPortout, BusMuxInYout, BusMuxInHI, BusMuxInLO, BusMuxInRamout out 32 each: register contents; BusMuxInRamout = RAM[MAR].
- output_data out 32: out-port register.
- irOut out 32: IR contents.
- branchCompare out 1: condition result.
- R0out..R15out out 1 each: decoded register bus-drive enables.
- R0in..R15in out 1 each: decoded register load enables.
- to_decode out 4: selected register index.

Behaviour:
- clear (async) zeroes all registers, Z, HI, LO, ports and MDR. RAM is not cleared.
- All loads occur on the Clock rising edge while the corresponding *in signal is high.

IR fields:
- opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- C = IR[18:0], sign-extended to 32 bits.
- C2 = IR[20:19].

Select/encode (combinational):
- to_decode = (Gra ? Ra : 0) | (Grb ? Rb : 0) | (Grc ? Rc : 0).
- Decode to_decode one-hot to sel[15:0].
- Rxin = Rin & sel[x].
- Rxout = (Rout | BAOut) & sel[x].

Bus:
- Combinational mux with fixed priority: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C (Cout), Y, RAM.
- No driver selected: bus = 0.
- R0 drives 0 when BAOut is asserted, otherwise R0's contents.

ALU:
- Inputs A = Y, B = bus; 64-bit result, written to Z[63:32] on ZHighin and Z[31:0] on Zlowin.
- IncPC overrides op: result = B + 1.
- op 00000: result = B. 00011 add, 00100 sub (A−B), 00101 and, 00110 or.
- op 00111 ror, 01000 rol, 01001 shr, 01010 shra, 01011 shl: A shifted by B[4:0].
- op 01111 mul: signed 64-bit product.
- op 10000 div: Z low = quotient, Z high = remainder; divide by 0 gives 0.
- op 10001 neg (−B), 10010 not (~B).
- Any other op: result 0.
- Unless stated otherwise, the high word is 0.

Memory:
- RAM read is asynchronous at MAR[8:0].
- MDRin: MDR <= Read ? RAM[MAR] : bus.
- Write: RAM[MAR] <= MDR on the edge. Simultaneous Read and Write reads the old data.
- MARin loads bus[31:0]; only bits [8:0] address RAM.

Ports:
- strobe loads input_data into InPort every edge it is high.
- OutPortin loads bus into output_data.

branchCompare (combinational on bus and C2):
- 00: bus==0.
- 01: bus!=0.
- 10: bus[31]==0 && bus!=0.
- 11: bus[31]==1.

Optional Feature:
- DATAPATH_RAM_INIT_EN defined: RAM is preloaded from RAM_INIT_FILE ($readmemh) at time 0.
- Undefined: RAM powers up as 0 (initial loop).

Decomposition:
- Package data_path_pkg: ALU op codes, C2 condition codes, IR field bit positions, and DATA_W=32.
- One sub-module is natural: alu (A, B, op, IncPC → 64-bit result).
- The register file, bus mux and select logic stay inline.

Test Plan:
- Load sequence:
  - Setup: clear; RAM[0]=0x00800065 (ld R1,0x65(R0)); RAM[0x65]=0x00000084.
  - Stimulus: run T0–T7 (PCout/MARin/IncPC/Z; Zlowout/PCin/Read/MDRin; MDRout/IRin; Grb/BAOut/Yin; Cout/Z with op=00011; Zlowout/MARin; Read/MDRin; Gra/Rin/MDRout).
  - Required: PC=1, irOut=0x00800065, BusMuxInR1=0x84, to_decode=1 in T7.
- BAOut with Rb=R0, R0 holding 0x55: BusOut=0 and Y=0. Rout with the same select: BusOut=0x55.
- Store: MAR=0x10, MDR=0xDEADBEEF, Write one cycle → BusMuxInRamout=0xDEADBEEF with RAMout driving the bus.
- Branch:
  - IR=0x00100000 (C2=10), MDRout with MDR=50 → branchCompare=1.
  - MDR=0 → 0.
  - MDR=0xFFFFFFFF with C2=11 → 1.
- ALU ops:
  - Y=7, bus=3: sub → ZLow=4.
  - mul with bus=−2 → Z=0xFFFFFFFF_FFFFFFF2.
  - div 7/3 → ZLow=2, ZHigh=1.
- Reset mid-operation: assert clear during T4 → all BusMuxIn* values except Ramout read 0 immediately, asynchronously, without waiting for a Clock edge.
